// File: rtl/cb1_alarm_ctrl.sv
// Alarm qualifier for the cb1 decoder output: debounces `l`, latches an alarm until ack,
// then enforces a hold-off. Optional auto-acknowledge timer under CB1_ALARM_TIMEOUT_EN.
module cb1_alarm_ctrl #(
    parameter int unsigned QUAL_CYC    = 4,
    parameter int unsigned HOLD_CYC    = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             l,
    input  logic             ack,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] event_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {StIdle = 2'd0, StQual = 2'd1, StAlarm = 2'd2, StHold = 2'd3} state_e;

    localparam logic [7:0]       QualLast = 8'(QUAL_CYC - 1);
    localparam logic [7:0]       HoldLast = 8'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       qcnt_q, qcnt_d;
    logic [7:0]       hcnt_q, hcnt_d;
    logic             alarm_q, alarm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef CB1_ALARM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TimeLast = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        hcnt_d  = hcnt_q;
        alarm_d = alarm_q;
        cnt_d   = cnt_q;
`ifdef CB1_ALARM_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (l) begin
                    if (QUAL_CYC == 1) begin
                        state_d = StAlarm;
                        alarm_d = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
                    end else begin
                        state_d = StQual;
                        qcnt_d  = 8'd1;
                    end
                end
            end
            StQual: begin
                if (!l) begin
                    // Any low sample discards accumulated credit.
                    state_d = StIdle;
                    qcnt_d  = 8'd0;
                end else if (qcnt_q == QualLast) begin
                    state_d = StAlarm;
                    qcnt_d  = 8'd0;
                    alarm_d = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
                end else begin
                    qcnt_d = qcnt_q + 8'd1;
                end
            end
            StAlarm: begin
                if (ack) begin
                    state_d = StHold;
                    alarm_d = 1'b0;
                    hcnt_d  = 8'd0;
`ifdef CB1_ALARM_TIMEOUT_EN
                    tcnt_d  = '0;
                end else if (tcnt_q == TimeLast) begin
                    state_d   = StHold;
                    alarm_d   = 1'b0;
                    hcnt_d    = 8'd0;
                    tcnt_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
`endif
                end
            end
            StHold: begin
                if (hcnt_q == HoldLast) begin
                    state_d = StIdle;
                    hcnt_d  = 8'd0;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            qcnt_q  <= 8'd0;
            hcnt_q  <= 8'd0;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            hcnt_q  <= hcnt_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CB1_ALARM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign alarm     = alarm_q;
    assign state     = state_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_cb1_alarm_ctrl.sv
// Directed bench for cb1_alarm_ctrl: default instance plus a CNT_W=2 instance for saturation.
module tb_cb1_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       l;
    logic       ack;
    logic       alarm;
    logic [1:0] state;
    logic [7:0] event_cnt;
    logic       timeout;
    logic       sat_alarm;
    logic [1:0] sat_state;
    logic [1:0] sat_cnt;
    logic       sat_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb1_alarm_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l         (l),
        .ack       (ack),
        .alarm     (alarm),
        .state     (state),
        .event_cnt (event_cnt),
        .timeout   (timeout)
    );

    cb1_alarm_ctrl #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .l         (l),
        .ack       (ack),
        .alarm     (sat_alarm),
        .state     (sat_state),
        .event_cnt (sat_cnt),
        .timeout   (sat_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sa(input string tag, input logic [1:0] es, input logic ea);
        checks++;
        assert ({state, alarm} === {es, ea}) else begin
            errors++;
            $error("FAIL %s: state/alarm got %0d/%0b want %0d/%0b", tag, state, alarm, es, ea);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] e);
        checks++;
        assert (event_cnt === e) else begin
            errors++;
            $error("FAIL %s: event_cnt got %0d want %0d", tag, event_cnt, e);
        end
    endtask

    task automatic chk_sat(input string tag, input logic [1:0] e);
        checks++;
        assert (sat_cnt === e) else begin
            errors++;
            $error("FAIL %s: sat event_cnt got %0d want %0d", tag, sat_cnt, e);
        end
    endtask

    task automatic chk_to(input string tag, input logic e);
        checks++;
        assert (timeout === e) else begin
            errors++;
            $error("FAIL %s: timeout got %0b want %0b", tag, timeout, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        l     = 1'b0;
        ack   = 1'b0;
        step();
        chk_sa("reset", 2'd0, 1'b0);
        chk_cnt("reset_cnt", 8'd0);
        chk_to("reset_to", 1'b0);
        rst_n = 1'b1;

        // Idle with l low, ack ignored outside ALARM
        for (int i = 0; i < 10; i++) begin
            ack = (i == 3);
            step();
            chk_sa("idle_low", 2'd0, 1'b0);
        end
        ack = 1'b0;
        chk_cnt("idle_cnt", 8'd0);

        // Qualification latency: alarm after the 4th high sample
        l = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_sa("qual", 2'd1, 1'b0);
        end
        step();
        chk_sa("alarm_raise", 2'd2, 1'b1);
        chk_cnt("alarm_cnt1", 8'd1);

        // Mid-ALARM reset
        rst_n = 1'b0;
        step();
        chk_sa("mid_reset", 2'd0, 1'b0);
        chk_cnt("mid_reset_cnt", 8'd0);
        rst_n = 1'b1;
        l     = 1'b0;
        step();

        // Interrupted burst earns no credit
        l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_sa("burst1", 2'd1, 1'b0);
        end
        l = 1'b0;
        step();
        chk_sa("burst_break", 2'd0, 1'b0);
        l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_sa("burst2", 2'd1, 1'b0);
        end
        step();
        chk_sa("burst2_alarm", 2'd2, 1'b1);
        chk_cnt("burst2_cnt", 8'd1);
        l = 1'b0;
        step();
        chk_sa("alarm_ignores_l", 2'd2, 1'b1);

        // Ack, hold-off with l high, then re-qualification
        l   = 1'b1;
        ack = 1'b1;
        step();
        chk_sa("ack_to_hold", 2'd3, 1'b0);
        ack = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk_sa("hold", 2'd3, 1'b0);
        end
        step();
        chk_sa("hold_exit", 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_sa("requal", 2'd1, 1'b0);
        end
        step();
        chk_sa("realarm", 2'd2, 1'b1);
        chk_cnt("realarm_cnt", 8'd2);

        // Saturation on the CNT_W=2 instance over five alarm/ack cycles
        rst_n = 1'b0;
        l     = 1'b0;
        step();
        rst_n = 1'b1;
        chk_sat("sat_reset", 2'd0);
        for (int n = 1; n <= 5; n++) begin
            l = 1'b1;
            repeat (4) step();
            chk_sa("sat_alarm", 2'd2, 1'b1);
            chk_cnt("sat_ref_cnt", 8'(n));
            chk_sat("sat_cnt", (n > 3) ? 2'd3 : 2'(n));
            l   = 1'b0;
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk_sa("sat_hold", 2'd3, 1'b0);
            repeat (8) step();
            chk_sa("sat_idle", 2'd0, 1'b0);
        end

        // Ack held across ALARM entry is consumed only on a later edge
        l   = 1'b1;
        ack = 1'b1;
        repeat (3) step();
        chk_sa("ack_early_qual", 2'd1, 1'b0);
        step();
        chk_sa("ack_early_entry", 2'd2, 1'b1);
        step();
        chk_sa("ack_early_hold", 2'd3, 1'b0);
        ack = 1'b0;
        l   = 1'b0;
        repeat (8) step();

`ifdef CB1_ALARM_TIMEOUT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        l     = 1'b1;
        repeat (4) step();
        l = 1'b0;
        chk_sa("to_alarm", 2'd2, 1'b1);
        repeat (15) step();
        chk_sa("to_pending", 2'd2, 1'b1);
        chk_to("to_pending_flag", 1'b0);
        step();
        chk_sa("to_expire", 2'd3, 1'b0);
        chk_to("to_set", 1'b1);
        repeat (8) step();
        chk_sa("to_idle", 2'd0, 1'b0);
        chk_to("to_sticky", 1'b1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        l     = 1'b1;
        repeat (4) step();
        l = 1'b0;
        repeat (15) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_sa("to_ack_wins", 2'd3, 1'b0);
        chk_to("to_ack_flag", 1'b0);
`else
        chk_to("to_disabled", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
